// File: rtl/mat_store.sv
// Two-slot matrix store: row-major streaming writes, zero-latency reads.
// Feeds the matrix adder's single read port.
module mat_store #(
  parameter int DIM_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_start,
  input  logic                  wr_slot,
  input  logic [DIM_WIDTH-1:0]  wr_m,
  input  logic [DIM_WIDTH-1:0]  wr_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_elem,
  input  logic                  wr_abort,
  output logic                  wr_ready,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  wr_error,
  output logic [1:0]            slot_valid,
  output logic [DIM_WIDTH-1:0]  slot0_m,
  output logic [DIM_WIDTH-1:0]  slot0_n,
  output logic [DIM_WIDTH-1:0]  slot1_m,
  output logic [DIM_WIDTH-1:0]  slot1_n,
  input  logic                  rd_en,
  input  logic                  rd_slot_idx,
  input  logic [DIM_WIDTH-1:0]  rd_row_idx,
  input  logic [DIM_WIDTH-1:0]  rd_col_idx,
  output logic [DATA_WIDTH-1:0] rd_elem,
  output logic                  rd_elem_valid,
  output logic                  rd_err
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int AW    = $clog2(2 * DEPTH);
  localparam logic [DIM_WIDTH-1:0] MAXD = DIM_WIDTH'(MAX_DIM);
  localparam logic [DIM_WIDTH-1:0] ONE  = DIM_WIDTH'(1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_LOAD,
    W_DONE,
    W_ERR
  } wstate_t;

  wstate_t state_q, state_d;

  logic                 slot_q;
  logic [DIM_WIDTH-1:0] m_q, n_q;
  logic [DIM_WIDTH-1:0] row_q, col_q;
  logic [1:0]           valid_q;
  logic [1:0][DIM_WIDTH-1:0] sm_q, sn_q;

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  logic          dims_ok;
  logic          start_ok;
  logic          elem_we;
  logic          col_last;
  logic          row_last;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic [DIM_WIDTH-1:0] rd_m, rd_n;
  logic                 rd_ok;

  assign dims_ok = (wr_m != '0) && (wr_n != '0) &&
                   (wr_m <= MAXD) && (wr_n <= MAXD);

  assign col_last = (col_q == n_q - ONE);
  assign row_last = (row_q == m_q - ONE);

  assign wr_addr = (slot_q ? AW'(DEPTH) : '0) +
                   AW'(row_q) * AW'(MAX_DIM) + AW'(col_q);

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    wr_busy  = 1'b0;
    wr_done  = 1'b0;
    wr_error = 1'b0;
    start_ok = 1'b0;
    elem_we  = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (wr_start) begin
          start_ok = dims_ok;
          state_d  = dims_ok ? W_LOAD : W_ERR;
        end
      end
      W_LOAD: begin
        wr_ready = 1'b1;
        wr_busy  = 1'b1;
        // abort wins over an element offered in the same cycle
        if (wr_abort) begin
          state_d = W_IDLE;
        end else if (wr_valid) begin
          elem_we = 1'b1;
          if (row_last && col_last) state_d = W_DONE;
        end
      end
      W_DONE: begin
        wr_done = 1'b1;
        state_d = W_IDLE;
      end
      W_ERR: begin
        wr_error = 1'b1;
        state_d  = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      slot_q  <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= '0;
      sm_q    <= '0;
      sn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        slot_q           <= wr_slot;
        m_q              <= wr_m;
        n_q              <= wr_n;
        row_q            <= '0;
        col_q            <= '0;
        valid_q[wr_slot] <= 1'b0;
        sm_q[wr_slot]    <= '0;
        sn_q[wr_slot]    <= '0;
      end
      if (elem_we) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + ONE;
        end else begin
          col_q <= col_q + ONE;
        end
        // slot becomes readable in the same cycle wr_done pulses
        if (row_last && col_last) begin
          valid_q[slot_q] <= 1'b1;
          sm_q[slot_q]    <= m_q;
          sn_q[slot_q]    <= n_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (elem_we) mem[wr_addr] <= wr_elem;
  end

  assign rd_m = sm_q[rd_slot_idx];
  assign rd_n = sn_q[rd_slot_idx];

  assign rd_ok = rd_en && valid_q[rd_slot_idx] &&
                 (rd_row_idx < rd_m) && (rd_col_idx < rd_n);

  assign rd_addr = (rd_slot_idx ? AW'(DEPTH) : '0) +
                   AW'(rd_row_idx) * AW'(MAX_DIM) + AW'(rd_col_idx);

  assign rd_elem       = rd_ok ? mem[rd_addr] : '0;
  assign rd_elem_valid = rd_ok;
  assign rd_err        = rd_en && !rd_ok;

  assign slot_valid = valid_q;
  assign slot0_m    = sm_q[0];
  assign slot0_n    = sn_q[0];
  assign slot1_m    = sm_q[1];
  assign slot1_n    = sn_q[1];

endmodule
